// File: rtl/top_mac_pkg.sv
// Shared types and helpers for the pipelined multiply-accumulate unit.
package top_mac_pkg;

  localparam int MIN_STAGES = 4;

  function automatic int prod_w(input int a_w, input int b_w);
    return a_w + b_w + 1;
  endfunction

  typedef struct packed {
    logic valid;
    logic acc_en;
    logic last;
  } mac_ctrl_t;

endpackage

// File: rtl/top_mac_delay_line.sv
// WIDTH x DEPTH shift register with clock enable and synchronous reset.
// DEPTH=0 degenerates to a wire.
module top_mac_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ctl;
      assign unused_ctl = ^{clk, reset, ce};
      assign q = d;
    end else begin : g_regs
      logic [WIDTH-1:0] pipe [DEPTH];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else if (ce) begin
          pipe[0] <= d;
          for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign q = pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/top_mac_pipe_dsp.sv
// Pipelined, packet-framed multiply-accumulate unit.
// Build option: TOP_MAC_SAT_EN makes the accumulator saturate instead of wrap.
module top_mac_pipe_dsp
  import top_mac_pkg::*;
#(
  parameter int A_W      = 16,
  parameter int B_W      = 8,
  parameter int B_SIGNED = 0,
  parameter int ACC_W    = 32,
  parameter int STAGES   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [A_W-1:0]   din0,
  input  logic [B_W-1:0]   din1,
  input  logic             acc_en,
  input  logic             last,
  output logic             out_valid,
  output logic [ACC_W-1:0] dout,
  output logic             ovf
);

  localparam int PW = prod_w(A_W, B_W);
  localparam int CW = $bits(mac_ctrl_t);

  generate
    if (STAGES < MIN_STAGES) begin : g_bad_stages
      $fatal(1, "top_mac_pipe_dsp: STAGES must be at least %0d", MIN_STAGES);
    end
    if (ACC_W < PW) begin : g_bad_acc_w
      $fatal(1, "top_mac_pipe_dsp: ACC_W must be at least A_W+B_W+1");
    end
  endgenerate

  // S1: operand and control capture
  logic signed [A_W-1:0] a_r;
  logic [B_W-1:0]        b_r;
  mac_ctrl_t             ctrl1;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_r   <= '0;
      b_r   <= '0;
      ctrl1 <= '0;
    end else if (ce) begin
      a_r          <= din0;
      b_r          <= din1;
      ctrl1.valid  <= in_valid;
      ctrl1.acc_en <= acc_en;
      ctrl1.last   <= last;
    end
  end

  // S2: product, widened by one bit on B so unsigned operands stay positive
  logic signed [B_W:0]      b_x;
  logic signed [PW-1:0]     prod_c;
  logic signed [ACC_W-1:0]  prod2;
  mac_ctrl_t                ctrl2;

  assign b_x    = (B_SIGNED != 0) ? $signed({b_r[B_W-1], b_r}) : $signed({1'b0, b_r});
  assign prod_c = PW'(a_r) * PW'(b_x);

  always_ff @(posedge clk) begin
    if (reset) begin
      prod2 <= '0;
      ctrl2 <= '0;
    end else if (ce) begin
      prod2 <= ACC_W'(prod_c);
      ctrl2 <= ctrl1;
    end
  end

  logic [ACC_W+CW-1:0]     dl_q;
  logic signed [ACC_W-1:0] prod_d;
  mac_ctrl_t               ctrl_d;

  top_mac_delay_line #(
    .WIDTH (ACC_W + CW),
    .DEPTH (STAGES - MIN_STAGES)
  ) u_delay (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .d     ({prod2, ctrl2}),
    .q     (dl_q)
  );

  assign {prod_d, ctrl_d} = dl_q;

  // S(STAGES-1): accumulator with sticky signed-overflow flag
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] acc_add;
  logic                    add_ovf;
  logic                    acc_ovf;
  logic                    acc_done;

  assign sum     = acc + prod_d;
  assign add_ovf = (acc[ACC_W-1] == prod_d[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

`ifdef TOP_MAC_SAT_EN
  // both addends share a sign on overflow, so acc's sign gives the direction
  assign acc_add = add_ovf ? (acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                           : {1'b0, {(ACC_W-1){1'b1}}})
                           : sum;
`else
  assign acc_add = sum;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      acc_ovf  <= 1'b0;
      acc_done <= 1'b0;
    end else if (ce) begin
      acc_done <= ctrl_d.valid & ctrl_d.last;
      if (ctrl_d.valid) begin
        if (ctrl_d.acc_en) begin
          acc     <= acc_add;
          acc_ovf <= acc_ovf | add_ovf;
        end else begin
          acc     <= prod_d;
          acc_ovf <= 1'b0;
        end
      end
    end
  end

  // S(STAGES): output registers, dout/ovf only move with a completed sum
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      dout      <= '0;
      ovf       <= 1'b0;
    end else if (ce) begin
      out_valid <= acc_done;
      if (acc_done) begin
        dout <= acc;
        ovf  <= acc_ovf;
      end
    end
  end

endmodule
